// File: rtl/sifive_insight_tl_pkg.sv
// rtl/sifive_insight_tl_pkg.sv - TileLink opcodes, AMBA prot struct and beat-count helper
package sifive_insight_tl_pkg;

  // TileLink A-channel opcodes
  localparam logic [2:0] TL_A_PUT_FULL      = 3'd0;
  localparam logic [2:0] TL_A_PUT_PARTIAL   = 3'd1;
  localparam logic [2:0] TL_A_ARITHMETIC    = 3'd2;
  localparam logic [2:0] TL_A_LOGICAL       = 3'd3;
  localparam logic [2:0] TL_A_GET           = 3'd4;
  localparam logic [2:0] TL_A_HINT          = 3'd5;

  // TileLink D-channel opcodes
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] TL_D_HINT_ACK        = 3'd2;

  // Bit positions inside the 7-bit prot field
  localparam int PROT_BUFFERABLE = 0;
  localparam int PROT_MODIFIABLE = 1;
  localparam int PROT_READALLOC  = 2;
  localparam int PROT_WRITEALLOC = 3;
  localparam int PROT_PRIVILEGED = 4;
  localparam int PROT_SECURE     = 5;
  localparam int PROT_FETCH      = 6;

  typedef struct packed {
    logic fetch;
    logic secure;
    logic privileged;
    logic writealloc;
    logic readalloc;
    logic modifiable;
    logic bufferable;
  } tl_prot_t;

  // Shared state encoding for the A and D burst trackers
  typedef enum logic {
    BEAT_IDLE  = 1'b0,
    BEAT_BURST = 1'b1
  } beat_state_e;

  // Beats in a message: data-carrying opcodes span 2**size/beat_bytes beats, never fewer than one
  function automatic logic [31:0] tl_beats(input logic [7:0] size, input logic [2:0] opcode,
                                           input logic is_d, input int unsigned beat_bytes);
    logic        has_data;
    logic [31:0] bytes;
    logic [31:0] beats;
    if (is_d) has_data = (opcode == TL_D_ACCESS_ACK_DATA);
    else      has_data = (opcode <= TL_A_LOGICAL);
    bytes = (size > 8'd31) ? 32'h8000_0000 : (32'd1 << size);
    beats = has_data ? (bytes / beat_bytes) : 32'd1;
    if (beats == 32'd0) beats = 32'd1;
    return beats;
  endfunction

endpackage

// File: rtl/sifive_insight_tl_beat_counter.sv
// rtl/sifive_insight_tl_beat_counter.sv - first/last beat tracker for one TileLink channel
module sifive_insight_tl_beat_counter
  import sifive_insight_tl_pkg::*;
#(
  parameter int CNT_BITS = 4
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                fire_i,
  input  logic [CNT_BITS-1:0] beats_m1_i,
  output logic                first_o,
  output logic                last_o
);

  localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

  beat_state_e         state_q;
  logic [CNT_BITS-1:0] cnt_q;

  assign first_o = (state_q == BEAT_IDLE);
  assign last_o  = first_o ? (beats_m1_i == '0) : (cnt_q == CNT_ONE);

  // Idle until a multi-beat first beat fires, then count the remaining beats down to zero
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= BEAT_IDLE;
      cnt_q   <= '0;
    end else if (fire_i) begin
      case (state_q)
        BEAT_IDLE: begin
          if (beats_m1_i != '0) begin
            cnt_q   <= beats_m1_i;
            state_q <= BEAT_BURST;
          end
        end
        default: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state_q <= BEAT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/sifive_insight_tl_prot_tracker.sv
// rtl/sifive_insight_tl_prot_tracker.sv - passive TL A/D prot tracker; SIFIVE_INSIGHT_PROT_STATS_EN adds prot statistics counters
module sifive_insight_tl_prot_tracker
  import sifive_insight_tl_pkg::*;
#(
  parameter int SOURCE_BITS    = 4,
  parameter int SIZE_BITS      = 4,
  parameter int BEAT_BYTES     = 8,
  parameter int MAX_BEATS_BITS = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [6:0]             a_prot,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  output logic [6:0]             d_prot,
  output logic                   d_prot_valid,
  output logic [SOURCE_BITS:0]   outstanding,
  output logic                   err_prot_unstable,
  output logic                   err_source_reuse,
  output logic                   err_orphan_d
`ifdef SIFIVE_INSIGHT_PROT_STATS_EN
  ,
  output logic [31:0]            stat_priv_cnt,
  output logic [31:0]            stat_fetch_cnt,
  output logic [31:0]            stat_secure_cnt
`endif
);

  localparam int DEPTH = 1 << SOURCE_BITS;
  localparam logic [SOURCE_BITS:0] OUT_ONE = {{SOURCE_BITS{1'b0}}, 1'b1};

  logic                      a_fire, d_fire;
  logic                      a_first, a_last, d_first, d_last;
  logic [31:0]               a_beats, d_beats;
  logic [MAX_BEATS_BITS-1:0] a_beats_m1, d_beats_m1;

  logic [6:0]                table_q [DEPTH];
  logic [DEPTH-1:0]          live_q, live_d;
  logic [SOURCE_BITS:0]      outstanding_q, outstanding_d;
  logic [6:0]                burst_prot_q;
  logic                      d_hit_q;
  logic [6:0]                d_prot_q;
  logic [SOURCE_BITS-1:0]    d_src_q;
  logic                      err_prot_unstable_q, err_source_reuse_q, err_orphan_d_q;

  logic                      a_alloc, a_reuse, d_clear;
  logic [SOURCE_BITS-1:0]    d_clear_src;
  logic                      d_lookup_hit;
  logic [6:0]                d_lookup_prot;

  assign a_fire = a_valid & a_ready;
  assign d_fire = d_valid & d_ready;

  assign a_beats    = tl_beats(8'(a_size), a_opcode, 1'b0, BEAT_BYTES);
  assign d_beats    = tl_beats(8'(d_size), d_opcode, 1'b1, BEAT_BYTES);
  assign a_beats_m1 = MAX_BEATS_BITS'(a_beats - 32'd1);
  assign d_beats_m1 = MAX_BEATS_BITS'(d_beats - 32'd1);

  sifive_insight_tl_beat_counter #(.CNT_BITS(MAX_BEATS_BITS)) u_a_beats (
    .clock_i    (clock),
    .reset_ni   (reset_n),
    .fire_i     (a_fire),
    .beats_m1_i (a_beats_m1),
    .first_o    (a_first),
    .last_o     (a_last)
  );

  sifive_insight_tl_beat_counter #(.CNT_BITS(MAX_BEATS_BITS)) u_d_beats (
    .clock_i    (clock),
    .reset_ni   (reset_n),
    .fire_i     (d_fire),
    .beats_m1_i (d_beats_m1),
    .first_o    (d_first),
    .last_o     (d_last)
  );

  assign d_lookup_hit  = live_q[d_source];
  assign d_lookup_prot = d_lookup_hit ? table_q[d_source] : 7'h00;

  // Live-set bookkeeping: a D last beat frees its source, an A first beat (applied after) claims one
  always_comb begin
    live_d        = live_q;
    outstanding_d = outstanding_q;
    d_clear_src   = d_first ? d_source : d_src_q;
    d_clear       = d_fire & d_last & live_q[d_clear_src];
    a_alloc       = a_fire & a_first;
    // A source being freed by D in the same cycle is a legitimate reuse, not an error
    a_reuse       = a_alloc & live_q[a_source] & ~(d_clear & (d_clear_src == a_source));
    if (d_clear) live_d[d_clear_src] = 1'b0;
    if (a_alloc) live_d[a_source]    = 1'b1;
    if ((a_alloc & ~a_reuse) & ~d_clear)      outstanding_d = outstanding_q + OUT_ONE;
    else if (d_clear & ~(a_alloc & ~a_reuse)) outstanding_d = outstanding_q - OUT_ONE;
  end

  // Prot table has no reset; entries are only trusted while their live bit is set
  always_ff @(posedge clock) begin
    if (a_alloc) table_q[a_source] <= a_prot;
  end

  // Tracking state, held D lookup and sticky protocol error flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_q              <= '0;
      outstanding_q       <= '0;
      burst_prot_q        <= '0;
      d_hit_q             <= 1'b0;
      d_prot_q            <= '0;
      d_src_q             <= '0;
      err_prot_unstable_q <= 1'b0;
      err_source_reuse_q  <= 1'b0;
      err_orphan_d_q      <= 1'b0;
    end else begin
      live_q        <= live_d;
      outstanding_q <= outstanding_d;
      if (a_alloc && !a_last) burst_prot_q <= a_prot;
      if (a_fire && !a_first && (a_prot != burst_prot_q)) err_prot_unstable_q <= 1'b1;
      if (a_reuse) err_source_reuse_q <= 1'b1;
      if (d_fire && d_first) begin
        d_hit_q  <= d_lookup_hit;
        d_prot_q <= d_lookup_prot;
        d_src_q  <= d_source;
        if (!d_lookup_hit) err_orphan_d_q <= 1'b1;
      end
    end
  end

  // First D beat reads the table directly; later beats replay the value captured on the first
  always_comb begin
    d_prot_valid = 1'b0;
    d_prot       = 7'h00;
    if (!d_first) begin
      d_prot_valid = d_hit_q;
      d_prot       = d_prot_q;
    end else if (d_valid) begin
      d_prot_valid = d_lookup_hit;
      d_prot       = d_lookup_prot;
    end
  end

  assign outstanding       = outstanding_q;
  assign err_prot_unstable = err_prot_unstable_q;
  assign err_source_reuse  = err_source_reuse_q;
  assign err_orphan_d      = err_orphan_d_q;

`ifdef SIFIVE_INSIGHT_PROT_STATS_EN
  tl_prot_t    a_prot_s;
  logic [31:0] stat_priv_q, stat_fetch_q, stat_secure_q;

  assign a_prot_s = tl_prot_t'(a_prot);

  // Saturating per-attribute counts of A messages, sampled on first beats only
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_priv_q   <= '0;
      stat_fetch_q  <= '0;
      stat_secure_q <= '0;
    end else if (a_alloc) begin
      if (a_prot_s.privileged && (stat_priv_q != '1))   stat_priv_q   <= stat_priv_q + 32'd1;
      if (a_prot_s.fetch      && (stat_fetch_q != '1))  stat_fetch_q  <= stat_fetch_q + 32'd1;
      if (a_prot_s.secure     && (stat_secure_q != '1)) stat_secure_q <= stat_secure_q + 32'd1;
    end
  end

  assign stat_priv_cnt   = stat_priv_q;
  assign stat_fetch_cnt  = stat_fetch_q;
  assign stat_secure_cnt = stat_secure_q;
`endif

endmodule

// File: tb/tb_sifive_insight_tl_prot_tracker.sv
// tb/tb_sifive_insight_tl_prot_tracker.sv - scoreboard bench for the TL prot tracker
`timescale 1ns/1ps
module tb_sifive_insight_tl_prot_tracker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       a_valid = 1'b0, a_ready = 1'b0;
  logic [2:0] a_opcode = '0;
  logic [3:0] a_size = '0, a_source = '0;
  logic [6:0] a_prot = '0;
  logic       d_valid = 1'b0, d_ready = 1'b0;
  logic [2:0] d_opcode = '0;
  logic [3:0] d_size = '0, d_source = '0;
  logic [6:0] d_prot;
  logic       d_prot_valid;
  logic [4:0] outstanding;
  logic       err_prot_unstable, err_source_reuse, err_orphan_d;
`ifdef SIFIVE_INSIGHT_PROT_STATS_EN
  logic [31:0] stat_priv_cnt, stat_fetch_cnt, stat_secure_cnt;
`endif

  sifive_insight_tl_prot_tracker dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .a_valid           (a_valid),
    .a_ready           (a_ready),
    .a_opcode          (a_opcode),
    .a_size            (a_size),
    .a_source          (a_source),
    .a_prot            (a_prot),
    .d_valid           (d_valid),
    .d_ready           (d_ready),
    .d_opcode          (d_opcode),
    .d_size            (d_size),
    .d_source          (d_source),
    .d_prot            (d_prot),
    .d_prot_valid      (d_prot_valid),
    .outstanding       (outstanding),
    .err_prot_unstable (err_prot_unstable),
    .err_source_reuse  (err_source_reuse),
    .err_orphan_d      (err_orphan_d)
`ifdef SIFIVE_INSIGHT_PROT_STATS_EN
    ,
    .stat_priv_cnt     (stat_priv_cnt),
    .stat_fetch_cnt    (stat_fetch_cnt),
    .stat_secure_cnt   (stat_secure_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] op;
    logic [3:0] size;
    logic [3:0] src;
    logic [6:0] prot;
    int         bad_beat;
    logic [6:0] bad_prot;
  } a_txn_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] size;
    logic [3:0] src;
  } d_txn_t;

  typedef struct {
    logic       hit;
    logic [6:0] prot;
  } exp_t;

  a_txn_t     aq[$];
  d_txn_t     dq[$];
  exp_t       exp_q[$];

  logic [15:0] m_live;
  logic [6:0]  m_tbl [16];
  logic        m_unstable, m_reuse, m_orphan;
  int          a_idx, d_idx;
  exp_t        d_cur;
  bit          auto_d;
  int          n_checks = 0;
  int          n_pass = 0;

  function automatic int a_beats(input a_txn_t t);
    int bytes = 1 << t.size;
    if (t.op <= 3'd3 && bytes > 8) return bytes / 8;
    return 1;
  endfunction

  function automatic int d_beats(input d_txn_t t);
    int bytes = 1 << t.size;
    if (t.op == 3'd1 && bytes > 8) return bytes / 8;
    return 1;
  endfunction

  function automatic a_txn_t mk_a(input int op, input int size, input int src, input int prot);
    a_txn_t t;
    t.op = 3'(op); t.size = 4'(size); t.src = 4'(src); t.prot = 7'(prot);
    t.bad_beat = -1; t.bad_prot = 7'(prot);
    return t;
  endfunction

  function automatic d_txn_t mk_d(input int op, input int size, input int src);
    d_txn_t t;
    t.op = 3'(op); t.size = 4'(size); t.src = 4'(src);
    return t;
  endfunction

  // Response a slave would send: Put -> AccessAck, Get/Atomic -> AccessAckData, Hint -> HintAck
  function automatic d_txn_t resp_for(input a_txn_t t);
    if (t.op <= 3'd1) return mk_d(0, t.size, t.src);
    if (t.op == 3'd5) return mk_d(2, t.size, t.src);
    return mk_d(1, t.size, t.src);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    aq.delete(); dq.delete(); exp_q.delete();
    m_live = '0; m_unstable = 0; m_reuse = 0; m_orphan = 0;
    a_idx = 0; d_idx = 0;
  endtask

  // One clock: present queue heads, update the reference model for whatever fires, then check status
  task automatic cycle(input bit force_rdy);
    a_txn_t at;
    d_txn_t dt;
    bit af, df, a_first, d_last;
    a_valid  = (aq.size() > 0);
    d_valid  = (dq.size() > 0);
    a_ready  = force_rdy || ($urandom_range(0, 3) != 0);
    d_ready  = force_rdy || ($urandom_range(0, 3) != 0);
    a_opcode = 3'($urandom); a_size = 4'($urandom); a_source = 4'($urandom); a_prot = 7'($urandom);
    d_opcode = 3'($urandom); d_size = 4'($urandom); d_source = 4'($urandom);
    if (a_valid) begin
      at = aq[0];
      a_opcode = at.op; a_size = at.size; a_source = at.src;
      a_prot = (a_idx == at.bad_beat) ? at.bad_prot : at.prot;
    end
    if (d_valid) begin
      dt = dq[0];
      d_opcode = dt.op; d_size = dt.size; d_source = dt.src;
    end
    af = a_valid && a_ready;
    df = d_valid && d_ready;
    a_first = af && (a_idx == 0);
    d_last  = df && (d_idx == d_beats(dt) - 1);
    if (df) begin
      if (d_idx == 0) begin
        d_cur.hit  = m_live[dt.src];
        d_cur.prot = m_tbl[dt.src];
        if (!m_live[dt.src]) m_orphan = 1;
      end
      exp_q.push_back(d_cur);
    end
    if (af && a_idx > 0 && a_prot != at.prot) m_unstable = 1;
    if (a_first && m_live[at.src] && !(d_last && dt.src == at.src)) m_reuse = 1;
    if (d_last) m_live[dt.src] = 1'b0;
    if (a_first) begin
      m_live[at.src] = 1'b1;
      m_tbl[at.src]  = at.prot;
      if (auto_d) dq.push_back(resp_for(at));
    end
    if (af) begin
      a_idx++;
      if (a_idx == a_beats(at)) begin void'(aq.pop_front()); a_idx = 0; end
    end
    if (df) begin
      d_idx++;
      if (d_idx == d_beats(dt)) begin void'(dq.pop_front()); d_idx = 0; end
    end
    @(posedge clock); #1;
    a_valid = 1'b0;
    d_valid = 1'b0;
    chk("outstanding", 32'(outstanding), 32'($countones(m_live)));
    chk("err_prot_unstable", 32'(err_prot_unstable), 32'(m_unstable));
    chk("err_source_reuse", 32'(err_source_reuse), 32'(m_reuse));
    chk("err_orphan_d", 32'(err_orphan_d), 32'(m_orphan));
  endtask

  task automatic run(input int budget, input bit force_rdy);
    int n = 0;
    while ((aq.size() > 0 || dq.size() > 0) && n < budget) begin
      cycle(force_rdy);
      n++;
    end
    n_checks++;
    if (aq.size() == 0 && dq.size() == 0) n_pass++;
    else $display("FAIL drain_timeout: %0d A and %0d D transactions still pending", aq.size(), dq.size());
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_d_prot_valid"}, 32'(d_prot_valid), 32'd0);
    chk({tag, "_d_prot"}, 32'(d_prot), 32'd0);
    chk({tag, "_outstanding"}, 32'(outstanding), 32'd0);
    chk({tag, "_err_prot_unstable"}, 32'(err_prot_unstable), 32'd0);
    chk({tag, "_err_source_reuse"}, 32'(err_source_reuse), 32'd0);
    chk({tag, "_err_orphan_d"}, 32'(err_orphan_d), 32'd0);
  endtask

  // Scoreboard monitor: every D beat that fires must match the next expected prot lookup
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && d_valid && d_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL d_unexpected_beat: src %0h with no expected entry", d_source);
      end else begin
        e = exp_q.pop_front();
        chk("d_prot_valid", 32'(d_prot_valid), 32'(e.hit));
        if (e.hit) chk("d_prot", 32'(d_prot), 32'(e.prot));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    a_txn_t t;
    model_reset();
    auto_d = 0;
    repeat (3) @(posedge clock);
    #1;
    chk_all_zero("reset");
    reset_n = 1'b1;
    cycle(1);

    // Get on source 3 then an 8-beat AccessAckData
    aq.push_back(mk_a(4, 6, 3, 'h02));
    run(20, 1);
    chk("get3_outstanding", 32'(outstanding), 32'd1);
    dq.push_back(mk_d(1, 6, 3));
    run(40, 0);
    chk("ack3_outstanding", 32'(outstanding), 32'd0);

    // 4-beat PutFull whose prot changes on beat 3
    t = mk_a(0, 5, 7, 'h15);
    t.bad_beat = 2; t.bad_prot = 7'h55;
    aq.push_back(t);
    run(20, 1);
    chk("put7_unstable", 32'(err_prot_unstable), 32'd1);
    dq.push_back(mk_d(0, 5, 7));
    run(20, 1);
    chk("put7_unstable_sticky", 32'(err_prot_unstable), 32'd1);

    // Two Gets on source 5 back to back
    aq.push_back(mk_a(4, 3, 5, 'h11));
    aq.push_back(mk_a(4, 3, 5, 'h22));
    run(20, 1);
    chk("reuse5_err", 32'(err_source_reuse), 32'd1);
    chk("reuse5_outstanding", 32'(outstanding), 32'd1);
    dq.push_back(mk_d(1, 3, 5));
    run(20, 1);

    // AccessAck for source 9 that was never requested
    dq.push_back(mk_d(0, 3, 9));
    run(20, 1);
    chk("orphan9_err", 32'(err_orphan_d), 32'd1);

    // Same-cycle A first beat and D last beat on source 2
    aq.push_back(mk_a(4, 3, 2, 'h01));
    run(20, 1);
    aq.push_back(mk_a(4, 3, 2, 'h40));
    dq.push_back(mk_d(0, 3, 2));
    cycle(1);
    chk("same_cycle_outstanding", 32'(outstanding), 32'd1);
    dq.push_back(mk_d(0, 3, 2));
    run(20, 1);
    chk("same_cycle_drain_outstanding", 32'(outstanding), 32'd0);

    // Reset in the middle of an A burst and a D burst
    aq.push_back(mk_a(4, 6, 1, 'h33));
    run(20, 1);
    aq.push_back(mk_a(0, 6, 4, 'h0c));
    dq.push_back(mk_d(1, 6, 1));
    repeat (3) cycle(1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_burst_reset");
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    aq.push_back(mk_a(4, 6, 6, 'h5a));
    run(20, 1);
    dq.push_back(mk_d(1, 6, 6));
    run(40, 1);
    chk("post_reset_outstanding", 32'(outstanding), 32'd0);
    chk("post_reset_errors", 32'({err_prot_unstable, err_source_reuse, err_orphan_d}), 32'd0);

    // Randomized traffic with automatically generated responses
    auto_d = 1;
    for (int i = 0; i < 150; i++) begin
      t = mk_a($urandom_range(0, 5), $urandom_range(0, 6), $urandom_range(0, 15), $urandom_range(0, 127));
      if (a_beats(t) > 1 && $urandom_range(0, 9) == 0) begin
        t.bad_beat = $urandom_range(1, a_beats(t) - 1);
        t.bad_prot = t.prot ^ 7'(1 << $urandom_range(0, 6));
      end
      aq.push_back(t);
      cycle(0);
    end
    run(5000, 0);
    cycle(1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
